ball_motion_ctrl: RTL and testbench

//  Game-logic stage directly upstream of the ball/pad renderer. Once per video frame it advances the

---
 rtl/vga_pkg.sv | 14 +
 rtl/ball_collide.sv | 87 ++++++++
 rtl/ball_motion_ctrl.sv | 127 ++++++++++++
 tb/tb_ball_motion_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared geometry and game-state encoding for the ball/pad video pipeline.
// Latency: none (constants and types only). Backpressure: not applicable.
// Used by ball_motion_ctrl and ball_collide; BALL_SPEEDUP_EN is consumed in ball_collide.
package vga_pkg;

    localparam int BALL_SIZE   = 15;
    localparam int PAD_WIDTH   = 10;
    localparam int PAD_HEIGHT  = 100;
    localparam int X_PAD_LEFT  = 30;
    localparam int X_PAD_RIGHT = 760;

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} ball_state_t;

endpackage

// File: rtl/ball_collide.sv
// Resolves one frame of ball motion: walls, pads and misses, each axis independently.
// Latency: combinational. Backpressure: none, evaluated every cycle and used on the frame tick.
// Optional macro BALL_SPEEDUP_EN: each pad hit increases |dx| by one up to MAX_SPEED_X.
module ball_collide
    import vga_pkg::*;
#(
    parameter int FIELD_W     = 800,
    parameter int FIELD_H     = 600,
    parameter int SPEED_Y     = 3,
    parameter int MAX_SPEED_X = 10
) (
    input  logic [10:0]       x,
    input  logic [9:0]        y,
    input  logic signed [5:0] dx,
    input  logic signed [5:0] dy,
    input  logic [9:0]        y_pad_left,
    input  logic [9:0]        y_pad_right,
    output logic [10:0]       x_nxt,
    output logic [9:0]        y_nxt,
    output logic signed [5:0] dx_nxt,
    output logic signed [5:0] dy_nxt,
    output logic              out_left,
    output logic              out_right
);

    localparam logic signed [11:0] BS     = 12'(BALL_SIZE);
    localparam logic signed [11:0] PH     = 12'(PAD_HEIGHT);
    localparam logic signed [11:0] L_EDGE = 12'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic signed [11:0] R_EDGE = 12'(X_PAD_RIGHT);
    localparam logic signed [11:0] W1     = 12'(FIELD_W - 1);
    localparam logic signed [11:0] H1     = 12'(FIELD_H - 1);
    localparam logic [5:0]         VMAX   = 6'(MAX_SPEED_X);

    logic signed [11:0] xs, ys, nx, ny, pl, pr;
    logic [5:0]         mag, mag_hit;
    logic               hit_left, hit_right;

    always_comb begin
        xs = signed'({1'b0, x});
        ys = signed'({2'b00, y});
        pl = signed'({2'b00, y_pad_left});
        pr = signed'({2'b00, y_pad_right});
        nx = xs + {{6{dx[5]}}, dx};
        ny = ys + {{6{dy[5]}}, dy};
        mag = dx[5] ? 6'(-dx) : 6'(dx);
`ifdef BALL_SPEEDUP_EN
        mag_hit = (mag >= VMAX) ? VMAX : mag + 6'd1;
`else
        mag_hit = (mag > VMAX) ? VMAX : mag;
`endif

        // Overlap uses the current y so the pad test matches what was on screen last frame.
        hit_left  = dx[5] && (xs > L_EDGE) && (nx <= L_EDGE)
                 && (ys + BS >= pl) && (ys <= pl + PH);
        hit_right = !dx[5] && (dx != 6'sd0) && (xs + BS < R_EDGE) && (nx + BS >= R_EDGE)
                 && (ys + BS >= pr) && (ys <= pr + PH);

        y_nxt  = ny[9:0];
        dy_nxt = dy;
        if (ny <= 12'sd0) begin
            y_nxt  = '0;
            dy_nxt = 6'(SPEED_Y);
        end else if (ny + BS >= H1) begin
            y_nxt  = 10'(FIELD_H - 1 - BALL_SIZE);
            dy_nxt = -6'(SPEED_Y);
        end

        x_nxt     = nx[10:0];
        dx_nxt    = dx;
        out_left  = 1'b0;
        out_right = 1'b0;
        if (hit_left) begin
            x_nxt  = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
            dx_nxt = signed'(mag_hit);
        end else if (hit_right) begin
            x_nxt  = 11'(X_PAD_RIGHT - BALL_SIZE - 1);
            dx_nxt = -signed'(mag_hit);
        end else if (nx <= 12'sd0) begin
            x_nxt    = '0;
            out_left = 1'b1;
        end else if (nx + BS >= W1) begin
            x_nxt     = 11'(FIELD_W - 1 - BALL_SIZE);
            out_right = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball game logic: serve/play/score FSM, frame counter and ball position registers.
// Latency: outputs update one clk after vblnk rises and hold for the frame. Backpressure: none.
// Optional macro BALL_SPEEDUP_EN (see ball_collide) enables pad-hit speed-up.
module ball_motion_ctrl
    import vga_pkg::*;
#(
    parameter int FIELD_W      = 800,
    parameter int FIELD_H      = 600,
    parameter int SPEED_X      = 4,
    parameter int SPEED_Y      = 3,
    parameter int MAX_SPEED_X  = 10,
    parameter int SERVE_FRAMES = 60,
    parameter int HOLD_FRAMES  = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        serve,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic        point_left,
    output logic        point_right,
    output logic        in_play
);

    localparam logic [10:0]        X_CTR = 11'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [9:0]         Y_CTR = 10'((FIELD_H - BALL_SIZE) / 2);
    localparam logic signed [5:0]  DX0   = 6'(SPEED_X);
    localparam logic signed [5:0]  DY0   = 6'(SPEED_Y);

    ball_state_t        state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [10:0]        x_q, x_d, cx;
    logic [9:0]         y_q, y_d, cy;
    logic signed [5:0]  dx_q, dx_d, dy_q, dy_d, cdx, cdy;
    logic               vblnk_q, tick, c_out_left, c_out_right, pl_d, pr_d;

    assign tick = vblnk & ~vblnk_q;

    ball_collide #(
        .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .SPEED_Y(SPEED_Y), .MAX_SPEED_X(MAX_SPEED_X)
    ) u_collide (
        .x(x_q), .y(y_q), .dx(dx_q), .dy(dy_q),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_nxt(cx), .y_nxt(cy), .dx_nxt(cdx), .dy_nxt(cdy),
        .out_left(c_out_left), .out_right(c_out_right)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        pl_d    = 1'b0;
        pr_d    = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: if (serve) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
                SERVE: if (cnt_q == 7'(SERVE_FRAMES - 1)) begin
                    state_d = PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
                PLAY: begin
                    x_d  = cx;
                    y_d  = cy;
                    dx_d = cdx;
                    dy_d = cdy;
                    pr_d = c_out_left;
                    pl_d = c_out_right;
                    if (c_out_left || c_out_right) begin
                        state_d = SCORED;
                        cnt_d   = '0;
                    end
                end
                SCORED: if (cnt_q == 7'(HOLD_FRAMES - 1)) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                    x_d     = X_CTR;
                    y_d     = Y_CTR;
                    // Frozen ball sits at x=0 only if the left player conceded.
                    dx_d    = (x_q == '0) ? -DX0 : DX0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= X_CTR;
            y_q         <= Y_CTR;
            dx_q        <= DX0;
            dy_q        <= DY0;
            vblnk_q     <= 1'b1;  // a vblnk already high at release is not a new frame
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            vblnk_q     <= vblnk;
            point_left  <= pl_d;
            point_right <= pr_d;
        end
    end

    assign x_ball  = x_q;
    assign y_ball  = y_q;
    assign in_play = (state_q == PLAY);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl, plus direct vectors on the ball_collide resolver.
module tb_ball_motion_ctrl;

`ifdef BALL_SPEEDUP_EN
    localparam int V2     = 5;
    localparam int K_MISS = 238;
`else
    localparam int V2     = 4;
    localparam int K_MISS = 275;
`endif

    logic        clk = 1'b0;
    logic        rst, vblnk, serve;
    logic [9:0]  y_pad_left, y_pad_right;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic        point_left, point_right, in_play;

    logic [10:0]       c_x, c_x_nxt;
    logic [9:0]        c_y, c_y_nxt, c_ypl, c_ypr;
    logic signed [5:0] c_dx, c_dy, c_dx_nxt, c_dy_nxt;
    logic              c_out_left, c_out_right;

    int n_cmp = 0;
    int n_bad = 0;
    int pl_cnt = 0;
    int pr_cnt = 0;

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .serve(serve),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_ball(x_ball), .y_ball(y_ball),
        .point_left(point_left), .point_right(point_right), .in_play(in_play)
    );

    ball_collide u_col (
        .x(c_x), .y(c_y), .dx(c_dx), .dy(c_dy), .y_pad_left(c_ypl), .y_pad_right(c_ypr),
        .x_nxt(c_x_nxt), .y_nxt(c_y_nxt), .dx_nxt(c_dx_nxt), .dy_nxt(c_dy_nxt),
        .out_left(c_out_left), .out_right(c_out_right)
    );

    always @(negedge clk) begin
        if (point_left)  pl_cnt++;
        if (point_right) pr_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) vblnk = 1'b1;
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic col(input int x, input int y, input int dx, input int dy,
                       input int ypl, input int ypr);
        c_x = 11'(x); c_y = 10'(y); c_dx = 6'(dx); c_dy = 6'(dy);
        c_ypl = 10'(ypl); c_ypr = 10'(ypr);
        #1;
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; serve = 1'b0;
        y_pad_left = 10'd0; y_pad_right = 10'd0;

        // Resolver vectors: walls, pads, pass-by, miss.
        col(400, 590, 4, 3, 0, 0);
        check("bot_wall_y", int'(c_y_nxt), 584);
        check("bot_wall_dy", int'(c_dy_nxt), -3);
        check("bot_wall_x", int'(c_x_nxt), 404);
        col(400, 584, 4, -3, 0, 0);
        check("after_bot_y", int'(c_y_nxt), 581);
        col(400, 2, 4, -3, 0, 0);
        check("top_wall_y", int'(c_y_nxt), 0);
        check("top_wall_dy", int'(c_dy_nxt), 3);
        col(42, 200, -4, 3, 150, 0);
        check("lpad_x", int'(c_x_nxt), 41);
        check("lpad_dx", int'(c_dx_nxt), V2);
        check("lpad_y", int'(c_y_nxt), 203);
        col(42, 200, -4, 3, 400, 0);
        check("lpass_x", int'(c_x_nxt), 38);
        check("lpass_dx", int'(c_dx_nxt), -4);
        check("lpass_out", int'(c_out_left), 0);
        col(744, 300, 4, 3, 0, 250);
        check("rpad_x", int'(c_x_nxt), 744);
        check("rpad_dx", int'(c_dx_nxt), -V2);
        check("rpad_out", int'(c_out_right), 0);
        col(3, 300, -4, 3, 0, 0);
        check("lmiss_x", int'(c_x_nxt), 0);
        check("lmiss_outl", int'(c_out_left), 1);
        check("lmiss_outr", int'(c_out_right), 0);

        // Reset and idle frames.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_x", int'(x_ball), 392);
        check("rst_y", int'(y_ball), 292);
        check("rst_play", int'(in_play), 0);
        frames(5);
        check("idle_x", int'(x_ball), 392);
        check("idle_y", int'(y_ball), 292);
        check("idle_play", int'(in_play), 0);
        check("idle_pts", pl_cnt + pr_cnt, 0);

        // Serve, then run to a right-edge miss with a simultaneous bottom clamp.
        serve = 1'b1;
        frame();
        serve = 1'b0;
        check("serve_play", int'(in_play), 0);
        frames(59);
        check("serve59_play", int'(in_play), 0);
        frame();
        check("serve60_play", int'(in_play), 1);
        check("serve60_x", int'(x_ball), 392);
        frame();
        check("k1_x", int'(x_ball), 396);
        check("k1_y", int'(y_ball), 295);
        frames(96);
        check("k97_x", int'(x_ball), 780);
        check("k97_y", int'(y_ball), 583);
        frame();
        check("rmiss_x", int'(x_ball), 784);
        check("rmiss_y", int'(y_ball), 584);
        check("rmiss_play", int'(in_play), 0);
        check("rmiss_pl", pl_cnt, 1);
        check("rmiss_pr", pr_cnt, 0);

        // Hold, re-centre, serve toward the right player, dy kept.
        serve = 1'b1;
        frames(89);
        serve = 1'b0;
        check("hold_x", int'(x_ball), 784);
        frame();
        check("recentre_x", int'(x_ball), 392);
        check("recentre_y", int'(y_ball), 292);
        frames(59);
        check("srv2_play0", int'(in_play), 0);
        frame();
        check("srv2_play1", int'(in_play), 1);
        frame();
        check("r2k1_x", int'(x_ball), 396);
        check("r2k1_y", int'(y_ball), 289);

        // Right pad bounce, top wall, then left-edge miss.
        frames(87);
        check("r2k88_x", int'(x_ball), 744);
        check("r2k88_y", int'(y_ball), 28);
        frame();
        check("r2pad_x", int'(x_ball), 744);
        frame();
        check("r2k90_x", int'(x_ball), 744 - V2);
        check("r2k90_y", int'(y_ball), 22);
        frames(8);
        check("r2top_y", int'(y_ball), 0);
        check("r2top_x", int'(x_ball), 744 - 9 * V2);
        frames(K_MISS - 1 - 98);
        check("pre_lmiss_x", int'(x_ball), 4);
        check("pre_lmiss_y", int'(y_ball), 3 * (K_MISS - 1 - 98));
        frame();
        check("lmiss_x", int'(x_ball), 0);
        check("lmiss_y", int'(y_ball), 3 * (K_MISS - 98));
        check("lmiss_play", int'(in_play), 0);
        check("lmiss_pr", pr_cnt, 1);
        check("lmiss_pl", pl_cnt, 1);
        frames(89);
        check("hold2_x", int'(x_ball), 0);
        frame();
        check("recentre2_x", int'(x_ball), 392);
        frames(60);
        check("srv3_play", int'(in_play), 1);
        frame();
        check("r3k1_x", int'(x_ball), 388);
        check("r3k1_y", int'(y_ball), 295);
        frame();
        check("r3k2_x", int'(x_ball), 384);

        // Reset mid-play; a vblnk rise during reset must not start a frame.
        @(negedge clk);
        rst = 1'b1; vblnk = 1'b1; serve = 1'b1;
        @(negedge clk);
        check("mrst_x", int'(x_ball), 392);
        check("mrst_y", int'(y_ball), 298 - 6);
        check("mrst_play", int'(in_play), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vblnk = 1'b0; serve = 1'b0;
        frames(61);
        check("post_rst_play", int'(in_play), 0);
        check("post_rst_x", int'(x_ball), 392);
        check("post_rst_pts", pl_cnt + pr_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
